key_debounce8: RTL and testbench
================================

# key_debounce8

Debounces and conditions eight raw switch/button inputs for the priority-encoder stage. Each raw line is synchronised and must hold a new value for a programmable number of sample ticks before it is accepted. The block outputs a clean level vector, which drives the encoder's `x` input, plus one-cycle rise and fall pulses per channel. One shared prescaler generates the sample tick, and each channel has its own stability counter.

## Interface
- `N`, 8: number of channels.
- `TICK_DIV`, 50000: clock cycles per sample tick; must be ≥1. A value of 1 means a tick every cycle.
- `STABLE_TICKS`, 4: consecutive differing ticks required to accept a new level; must be ≥1.
- `clk`  in  1  the block's single clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `raw`  in  N  asynchronous switch/button levels.
- `stable`  out  N  debounced level vector; feeds encoder `x`.
- `rise`  out  N  one-cycle pulse when `stable[i]` goes 0→1.
- `fall`  out  N  one-cycle pulse when `stable[i]` goes 1→0.
- `any_rise`  out  1  OR-reduction of `rise`, registered with it.
- `tick`  out  1  shared sample strobe, exported for debug and for the display scan.

## Operation
- **Synchroniser.** Each channel passes `raw[i]` through a two-flop chain `s1 → s2`. Only `s2` is used downstream.
- **Prescaler.**
  - Counter `pcnt` of width `clog2(TICK_DIV)` (minimum 1 bit) counts 0..`TICK_DIV`-1 and wraps.
  - `tick` is registered and is 1 for exactly the one cycle after `pcnt` reaches `TICK_DIV`-1.
- **Per-channel counter.** Each channel has a counter `scnt` of width `clog2(STABLE_TICKS+1)`. It updates only on `tick` cycles:
  - If `s2` equals `stable[i]`: `scnt` is cleared to 0.
  - Else, if `scnt+1 == STABLE_TICKS`: `stable[i]` is loaded with `s2` and `scnt` is cleared to 0.
  - Else: `scnt` is incremented.
- **Edge pulses.** `rise[i]` and `fall[i]` are registered. They assert in the same cycle that `stable[i]` changes, for exactly one cycle.
- **Channel independence.** Channels are fully independent. Simultaneous changes on several channels produce simultaneous pulses.
- **Counter range.** `scnt` never exceeds `STABLE_TICKS`-1, and there is no wrap-around path.
- **Reset.** `rst_n` low at any time, including mid-count, clears every register immediately:
  - `s1`, `s2`, `pcnt`, `scnt`, `stable`, `rise`, `fall`, `any_rise` and `tick` are all 0.
  - After reset, a channel held at 1 is treated as a fresh 0→1 change and produces a `rise`.

## Timing
- **Reset values.** All outputs are 0.
- **Synchroniser latency.** 2 cycles from a `raw` change to `s2`.
- **Acceptance latency.** From `s2` settling to the `stable` update is between (`STABLE_TICKS`-1)·`TICK_DIV`+1 and `STABLE_TICKS`·`TICK_DIV` cycles, plus 1 register cycle.
- **Glitches.** Any excursion of `s2` that returns to the `stable[i]` value before the `STABLE_TICKS`-th consecutive tick resets `scnt`, and `stable` does not change.
- **Tick period.** `tick` occurs exactly every `TICK_DIV` cycles with no jitter. The first tick occurs `TICK_DIV` cycles after reset release.
- **Pulse spacing.** `rise` and `fall` on the same channel are separated by at least `STABLE_TICKS` ticks.

## Structure
- **Shared package `key_pkg`.** Holds:
  - the default constants `KEY_N=8`, `KEY_TICK_DIV=50000`, `KEY_STABLE_TICKS=4`;
  - the simulation constants `KEY_TICK_DIV_SIM=4`, `KEY_STABLE_TICKS_SIM=3`.
- **Sub-module `key_debounce_ch`.** One per channel, containing the synchroniser, `scnt`, `stable` and the pulse flops, with `tick` as an input.
- **Top level.** Holds the prescaler, a generate loop of `N` `key_debounce_ch` instances, and the `any_rise` reduction.

## Test plan
All scenarios use `TICK_DIV`=4 and `STABLE_TICKS`=3.
- **Reset.** `rst_n`=0 with `raw`=8'hFF → all outputs 0. Release reset and hold `raw` → `stable`=8'hFF within 2+12+1 cycles, and `rise`=8'hFF for one cycle.
- **Clean press.** `raw[0]` goes 0→1 and is held → `stable[0]`=1 no earlier than 2+8 and no later than 2+12+1 cycles. Exactly one `rise[0]` pulse, with `any_rise`=1 in the same cycle.
- **Glitch.** `raw[3]` goes high for 6 cycles, then low → `stable`, `rise` and `fall` stay 0 throughout.
- **Bounce.** `raw[5]` toggles every 3 cycles for 40 cycles, then holds 1 → exactly one `rise[5]`, and no `fall[5]` afterwards.
- **Multi-channel release.** `raw` goes 8'h00→8'hA5 in one cycle and is held → `stable`=8'hA5 and `rise`=8'hA5 in the same cycle. Then `raw`→8'h00 → `fall`=8'hA5 in one cycle.
- **Reset mid-count.** `raw[7]`=1; assert `rst_n`=0 after 2 ticks → everything clears immediately. After release, `stable[7]` needs a full 3 new ticks before it asserts.

Source files
------------

// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared constants and helpers for the eight-channel key debouncer.
//   KEY_N                 : number of debounced channels
//   KEY_TICK_DIV          : clock cycles per sample tick for silicon
//   KEY_STABLE_TICKS      : consecutive differing ticks needed to accept a level
//   KEY_TICK_DIV_SIM      : short tick period used in simulation
//   KEY_STABLE_TICKS_SIM  : short acceptance window used in simulation
// -----------------------------------------------------------------------------
package key_pkg;

  localparam int KEY_N                = 8;
  localparam int KEY_TICK_DIV         = 50000;
  localparam int KEY_STABLE_TICKS     = 4;

  localparam int KEY_TICK_DIV_SIM     = 4;
  localparam int KEY_STABLE_TICKS_SIM = 3;

  // Counter width able to hold 0..value-1, never narrower than one bit so a
  // divide-by-one prescaler still has a legal register.
  function automatic int keyWidth(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_debounce8_if.sv
// -----------------------------------------------------------------------------
// key_debounce8_if
// Bundles the raw key levels and the conditioned outputs of key_debounce8.
//   raw      : asynchronous switch/button levels into the debouncer
//   stable   : debounced level vector (drives the priority encoder x input)
//   rise     : one-cycle pulse per channel on a 0->1 change of stable
//   fall     : one-cycle pulse per channel on a 1->0 change of stable
//   any_rise : OR of rise, aligned with it
//   tick     : shared sample strobe
// Modports: master = the side supplying raw keys and consuming the results,
//           slave  = the debouncer itself.
// -----------------------------------------------------------------------------
interface key_debounce8_if
  import key_pkg::*;
#(
  parameter int N = KEY_N
);

  logic [N-1:0] raw;
  logic [N-1:0] stable;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic         any_rise;
  logic         tick;

  modport master (
    output raw,
    input  stable,
    input  rise,
    input  fall,
    input  any_rise,
    input  tick
  );

  modport slave (
    input  raw,
    output stable,
    output rise,
    output fall,
    output any_rise,
    output tick
  );

endinterface

// File: rtl/key_debounce_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
// One debounce channel: two-flop synchroniser, stability counter, accepted
// level and registered edge pulses. All decisions are made on tick cycles only.
//   clk          : block clock
//   rst_n        : asynchronous active-low reset
//   i_raw        : raw asynchronous key level
//   i_tick       : shared sample strobe from the prescaler
//   o_stable     : accepted (debounced) level
//   o_rise       : registered one-cycle pulse when o_stable goes 0->1
//   o_fall       : registered one-cycle pulse when o_stable goes 1->0
//   o_riseNext   : combinational "rise will assert next cycle", so the parent
//                  can register any_rise in step with o_rise
// -----------------------------------------------------------------------------
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int STABLE_TICKS = KEY_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  input  logic i_tick,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall,
  output logic o_riseNext
);

  localparam int SW = keyWidth(STABLE_TICKS + 1);
  // Comparing against STABLE_TICKS-1 is the same test as scnt+1 == STABLE_TICKS
  // but cannot overflow the counter width.
  localparam logic [SW-1:0] SCNT_LAST = SW'(STABLE_TICKS - 1);

  logic          r_s1;
  logic          r_s2;
  logic [SW-1:0] r_scnt;
  logic          r_stable;
  logic          r_rise;
  logic          r_fall;

  logic          w_differ;
  logic          w_accept;
  logic          w_riseNext;
  logic          w_fallNext;

  // Acceptance happens on the tick that completes the run of differing
  // samples; the edge pulses are derived from that same decision so they
  // land in the cycle stable changes.
  always_comb begin
    w_differ   = r_s2 ^ r_stable;
    w_accept   = i_tick & w_differ & (r_scnt == SCNT_LAST);
    w_riseNext = w_accept & r_s2;
    w_fallNext = w_accept & ~r_s2;
  end

  // Synchroniser, stability counter, accepted level and pulse registers.
  // A sample matching the accepted level restarts the count, so any glitch
  // shorter than the window is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_scnt   <= '0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_s1   <= i_raw;
      r_s2   <= r_s1;
      r_rise <= w_riseNext;
      r_fall <= w_fallNext;
      if (i_tick) begin
        if (!w_differ) begin
          r_scnt <= '0;
        end else if (w_accept) begin
          r_stable <= r_s2;
          r_scnt   <= '0;
        end else begin
          r_scnt <= r_scnt + SW'(1);
        end
      end
    end
  end

  assign o_stable   = r_stable;
  assign o_rise     = r_rise;
  assign o_fall     = r_fall;
  assign o_riseNext = w_riseNext;

endmodule

// File: rtl/key_debounce8.sv
// -----------------------------------------------------------------------------
// key_debounce8
// Debounces N raw key inputs for the priority-encoder stage. A shared
// prescaler produces the sample tick; each channel has its own synchroniser
// and stability counter.
//   clk    : block clock
//   rst_n  : asynchronous active-low reset, clears every register
//   bus    : key_debounce8_if slave port (raw in; stable, rise, fall,
//            any_rise, tick out)
// Parameters:
//   N            : channel count
//   TICK_DIV     : clock cycles per sample tick (>= 1, 1 = every cycle)
//   STABLE_TICKS : consecutive differing ticks to accept a level (>= 1)
// -----------------------------------------------------------------------------
module key_debounce8
  import key_pkg::*;
#(
  parameter int N            = KEY_N,
  parameter int TICK_DIV     = KEY_TICK_DIV,
  parameter int STABLE_TICKS = KEY_STABLE_TICKS
) (
  input  logic            clk,
  input  logic            rst_n,
  key_debounce8_if.slave  bus
);

  localparam int            PW        = keyWidth(TICK_DIV);
  localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_pcnt;
  logic          r_tick;
  logic          r_anyRise;

  logic          w_pcntLast;
  logic [N-1:0]  w_stable;
  logic [N-1:0]  w_rise;
  logic [N-1:0]  w_fall;
  logic [N-1:0]  w_riseNext;

  assign w_pcntLast = (r_pcnt == PCNT_LAST);

  // Prescaler: pcnt wraps every TICK_DIV cycles and tick is registered from
  // the terminal count, giving a jitter-free strobe whose first pulse comes
  // TICK_DIV cycles after reset release. With TICK_DIV = 1 the counter sits
  // at zero and tick stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pcnt <= w_pcntLast ? '0 : r_pcnt + PW'(1);
      r_tick <= w_pcntLast;
    end
  end

  // Independent channels all sampled on the shared tick.
  for (genvar g = 0; g < N; g++) begin : gChannel
    key_debounce_ch #(
      .STABLE_TICKS (STABLE_TICKS)
    ) uChannel (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_raw      (bus.raw[g]),
      .i_tick     (r_tick),
      .o_stable   (w_stable[g]),
      .o_rise     (w_rise[g]),
      .o_fall     (w_fall[g]),
      .o_riseNext (w_riseNext[g])
    );
  end

  // any_rise is reduced from the channels' next-cycle rise terms so that,
  // once registered, it lines up exactly with the rise pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_anyRise <= 1'b0;
    end else begin
      r_anyRise <= |w_riseNext;
    end
  end

  assign bus.stable   = w_stable;
  assign bus.rise     = w_rise;
  assign bus.fall     = w_fall;
  assign bus.any_rise = r_anyRise;
  assign bus.tick     = r_tick;

endmodule

// File: tb/tb_key_debounce8.sv
// -----------------------------------------------------------------------------
// tb_key_debounce8
// Self-checking bench for key_debounce8 with the short simulation constants.
// A behavioural model tracks tick timing from the cycle count since reset,
// the two-cycle synchroniser delay and the run of differing tick samples per
// channel; every cycle the DUT outputs are compared against it, on top of
// directed scenario checks.
// -----------------------------------------------------------------------------
module tb_key_debounce8;
  import key_pkg::*;

  localparam int N  = KEY_N;
  localparam int TD = KEY_TICK_DIV_SIM;
  localparam int ST = KEY_STABLE_TICKS_SIM;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  key_debounce8_if #(.N(N)) bus ();

  key_debounce8 #(
    .N            (N),
    .TICK_DIV     (TD),
    .STABLE_TICKS (ST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Model state
  logic [N-1:0] mS1, mS2, mStable, mRise, mFall;
  logic         mAny, mTick;
  int           edgeCount;
  int           streak [N];

  // Observation accumulators
  logic         monitorOn = 1'b0;
  logic [N-1:0] riseSeen, fallSeen, stableSeen;
  int           riseCount [N];
  int           fallCount [N];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mS1 = '0; mS2 = '0; mStable = '0; mRise = '0; mFall = '0;
    mAny = 1'b0; mTick = 1'b0; edgeCount = 0;
    for (int i = 0; i < N; i++) streak[i] = 0;
  endtask

  // One clock edge of the reference: a channel accepts the synchronised
  // value once ST consecutive tick samples disagree with its accepted level.
  task automatic modelStep();
    mRise = '0;
    mFall = '0;
    if (mTick) begin
      for (int i = 0; i < N; i++) begin
        if (mS2[i] != mStable[i]) begin
          streak[i] = streak[i] + 1;
          if (streak[i] == ST) begin
            mStable[i] = mS2[i];
            if (mS2[i]) mRise[i] = 1'b1;
            else        mFall[i] = 1'b1;
            streak[i] = 0;
          end
        end else begin
          streak[i] = 0;
        end
      end
    end
    mAny      = |mRise;
    mS2       = mS1;
    mS1       = bus.raw;
    edgeCount = edgeCount + 1;
    mTick     = ((edgeCount % TD) == 0);
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else        modelStep();
    end
  end

  // Per-cycle comparison against the model plus scenario accumulators.
  initial begin
    forever begin
      @(negedge clk);
      if (monitorOn) begin
        checkOutput("cyc stable",   32'(bus.stable),   32'(mStable));
        checkOutput("cyc rise",     32'(bus.rise),     32'(mRise));
        checkOutput("cyc fall",     32'(bus.fall),     32'(mFall));
        checkOutput("cyc any_rise", 32'(bus.any_rise), 32'(mAny));
        checkOutput("cyc tick",     32'(bus.tick),     32'(mTick));
        riseSeen   = riseSeen | bus.rise;
        fallSeen   = fallSeen | bus.fall;
        stableSeen = stableSeen | bus.stable;
        for (int i = 0; i < N; i++) begin
          if (bus.rise[i]) riseCount[i]++;
          if (bus.fall[i]) fallCount[i]++;
        end
      end
    end
  end

  task automatic clearObs();
    riseSeen = '0; fallSeen = '0; stableSeen = '0;
    for (int i = 0; i < N; i++) begin
      riseCount[i] = 0;
      fallCount[i] = 0;
    end
  endtask

  // Called just after a rising edge; drives raw then holds it.
  task automatic applyStimulus(input logic [N-1:0] value, input int hold);
    bus.raw = value;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  // Waits (bounded) at falling edges until stable leaves the given value.
  task automatic waitUntilChange(input logic [N-1:0] from, input int limit,
                                 output logic ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      cycles = c;
      if (bus.stable != from) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic         ok;
    int           cycles;
    int           ticks;
    logic [N-1:0] cur;

    bus.raw = 8'hFF;
    clearObs();

    // Reset with all keys held
    @(posedge clk);
    @(negedge clk);
    monitorOn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset stable",   32'(bus.stable),   32'h0);
    checkOutput("reset rise",     32'(bus.rise),     32'h0);
    checkOutput("reset fall",     32'(bus.fall),     32'h0);
    checkOutput("reset any_rise", 32'(bus.any_rise), 32'h0);
    checkOutput("reset tick",     32'(bus.tick),     32'h0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    waitUntilChange(8'h00, 2 + 12 + 1, ok, cycles);
    checkOutput("release accepted", 32'(ok), 32'h1);
    checkOutput("release stable",   32'(bus.stable), 32'hFF);
    checkOutput("release rise",     32'(bus.rise),   32'hFF);
    checkOutput("release any_rise", 32'(bus.any_rise), 32'h1);

    // Clean press on channel 0
    @(posedge clk); #1;
    applyStimulus(8'h00, 25);
    checkOutput("all released", 32'(bus.stable), 32'h00);
    clearObs();
    applyStimulus(8'h01, 0);
    waitUntilChange(8'h00, 30, ok, cycles);
    checkOutput("press accepted", 32'(ok), 32'h1);
    checkOutput("press latency window", 32'((cycles >= 2 + 8) && (cycles <= 2 + 12 + 1)), 32'h1);
    checkOutput("press stable",   32'(bus.stable),   32'h01);
    checkOutput("press rise",     32'(bus.rise),     32'h01);
    checkOutput("press any_rise", 32'(bus.any_rise), 32'h1);
    @(posedge clk); #1;
    applyStimulus(8'h01, 20);
    checkOutput("press single rise", 32'(riseCount[0]), 32'd1);

    // Short glitch on channel 3
    clearObs();
    applyStimulus(8'h09, 6);
    applyStimulus(8'h01, 30);
    checkOutput("glitch ch3 quiet", 32'({stableSeen[3], riseSeen[3], fallSeen[3]}), 32'h0);

    // Bounce on channel 5, then hold high
    clearObs();
    for (int k = 0; k < 14; k++) begin
      applyStimulus((k % 2 == 0) ? 8'h21 : 8'h01, 3);
    end
    applyStimulus(8'h21, 30);
    checkOutput("bounce rise count", 32'(riseCount[5]), 32'd1);
    checkOutput("bounce fall count", 32'(fallCount[5]), 32'd0);
    checkOutput("bounce stable",     32'(bus.stable),   32'h21);

    // Multi-channel press and release
    applyStimulus(8'h00, 25);
    applyStimulus(8'hA5, 0);
    waitUntilChange(8'h00, 30, ok, cycles);
    checkOutput("multi accepted", 32'(ok), 32'h1);
    checkOutput("multi stable",   32'(bus.stable), 32'hA5);
    checkOutput("multi rise",     32'(bus.rise),   32'hA5);
    @(posedge clk); #1;
    applyStimulus(8'hA5, 10);
    applyStimulus(8'h00, 0);
    waitUntilChange(8'hA5, 30, ok, cycles);
    checkOutput("multi release accepted", 32'(ok), 32'h1);
    checkOutput("multi fall",     32'(bus.fall),   32'hA5);
    checkOutput("multi cleared",  32'(bus.stable), 32'h00);

    // Reset in the middle of a count on channel 7
    @(posedge clk); #1;
    applyStimulus(8'h00, 5);
    applyStimulus(8'h80, 0);
    ticks = 0;
    for (int c = 0; c < 20 && ticks < 2; c++) begin
      @(negedge clk);
      if (bus.tick) ticks++;
    end
    checkOutput("midcount ticks seen", 32'(ticks), 32'd2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset stable", 32'(bus.stable),   32'h0);
    checkOutput("midreset rise",   32'(bus.rise),     32'h0);
    checkOutput("midreset fall",   32'(bus.fall),     32'h0);
    checkOutput("midreset any",    32'(bus.any_rise), 32'h0);
    checkOutput("midreset tick",   32'(bus.tick),     32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ticks = 0;
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.tick) ticks++;
      if (bus.stable[7]) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("after reset accepted",    32'(ok), 32'h1);
    checkOutput("after reset ticks",       32'(ticks), 32'd3);
    checkOutput("after reset rise",        32'(bus.rise), 32'h80);

    // Randomised key activity against the model
    @(posedge clk); #1;
    cur = 8'h80;
    for (int s = 0; s < 60; s++) begin
      cur = cur ^ 8'($urandom_range(0, 255) & (($urandom_range(0, 3) == 0) ? 255 : (1 << $urandom_range(0, 7))));
      applyStimulus(cur, $urandom_range(1, 20));
    end
    applyStimulus(cur, 30);
    checkOutput("random settle", 32'(bus.stable), 32'(cur));

    monitorOn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
